turfio_cin_aligner: RTL

TURFIO_CIN_ALIGNER -- requirements
Module: turfio_cin_aligner

---
 rtl/turfio_cin_aligner_if.sv | 23 ++
 rtl/turfio_cin_aligner.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/turfio_cin_aligner_if.sv
// CIN aligner signal bundle: nibble input, lock control and aligned-word/status outputs.
interface turfio_cin_aligner_if;
   logic [3:0]  data_i;
   logic        data_ce_i;
   logic        lock_req_i;
   logic        lock_rst_i;
   logic        train_en_i;
   logic        lock_status_o;
   logic        cin_err_o;
   logic [31:0] word_o;
   logic        word_valid_o;
   logic [15:0] err_count_o;

   modport master (
      output data_i, data_ce_i, lock_req_i, lock_rst_i, train_en_i,
      input  lock_status_o, cin_err_o, word_o, word_valid_o, err_count_o
   );

   modport slave (
      input  data_i, data_ce_i, lock_req_i, lock_rst_i, train_en_i,
      output lock_status_o, cin_err_o, word_o, word_valid_o, err_count_o
   );
endinterface

// File: rtl/turfio_cin_aligner.sv
// CIN nibble-stream word aligner: finds the training word boundary, verifies it, then emits aligned words.
// Optional macro TURFIO_CIN_ERRCNT_EN adds a saturating 16-bit training-error counter on err_count_o.
//
// state  | meaning
// IDLE   | not aligned, waiting for lock_req_i
// SEARCH | checking every ce for the training word
// VERIFY | checking only boundary ces until LOCK_COUNT matches
// LOCKED | aligned; boundary ces emit words and check training
module turfio_cin_aligner #(
   parameter logic [31:0] TRAIN_PATTERN = 32'hA55A6996,
   parameter int unsigned LOCK_COUNT    = 8
) (
   input logic                 aclk_i,
   input logic                 rst_i,
   turfio_cin_aligner_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SEARCH, VERIFY, LOCKED} state_t;

   localparam logic [7:0] LOCK_CNT = 8'(LOCK_COUNT);

   state_t      state_q, state_d;
   logic [31:0] sr_q, sr_d;
   logic [31:0] word_q, word_d;
   logic [2:0]  phase_q, phase_d;
   logic [2:0]  offset_q, offset_d;
   logic [7:0]  match_cnt_q, match_cnt_d;
   logic        cin_err_q, cin_err_d;
   logic        word_valid_q, word_valid_d;
   logic [31:0] sr_shift;
   logic        match;
   logic        boundary;
   logic        train_bad;

   assign sr_shift  = {sr_q[27:0], bus.data_i};
   assign match     = (sr_shift == TRAIN_PATTERN);
   assign boundary  = bus.data_ce_i && (phase_q == offset_q);
   assign train_bad = bus.train_en_i && !match;

   always_ff @(posedge aclk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         sr_q         <= '0;
         word_q       <= '0;
         phase_q      <= '0;
         offset_q     <= '0;
         match_cnt_q  <= '0;
         cin_err_q    <= 1'b0;
         word_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         word_q       <= word_d;
         phase_q      <= phase_d;
         offset_q     <= offset_d;
         match_cnt_q  <= match_cnt_d;
         cin_err_q    <= cin_err_d;
         word_valid_q <= word_valid_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      word_d       = word_q;
      phase_d      = phase_q;
      offset_d     = offset_q;
      match_cnt_d  = match_cnt_q;
      cin_err_d    = cin_err_q;
      word_valid_d = 1'b0;

      // The shift register and phase run in every state; only the FSM decisions are gated.
      if (bus.data_ce_i) begin
         sr_d    = sr_shift;
         phase_d = phase_q + 3'd1;
      end

      if (bus.lock_rst_i) begin
         state_d     = IDLE;
         match_cnt_d = '0;
         cin_err_d   = 1'b0;
      end else if (bus.lock_req_i && (state_q == VERIFY || state_q == LOCKED)) begin
         state_d     = SEARCH;
         match_cnt_d = '0;
         cin_err_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.lock_req_i) state_d = SEARCH;
            end
            SEARCH: begin
               if (bus.data_ce_i && match) begin
                  offset_d    = phase_q;
                  match_cnt_d = 8'd1;
                  state_d     = (LOCK_CNT == 8'd1) ? LOCKED : VERIFY;
               end
            end
            VERIFY: begin
               if (boundary) begin
                  if (match) begin
                     match_cnt_d = match_cnt_q + 8'd1;
                     if (match_cnt_q + 8'd1 == LOCK_CNT) state_d = LOCKED;
                  end else begin
                     match_cnt_d = '0;
                     state_d     = SEARCH;
                  end
               end
            end
            LOCKED: begin
               if (boundary) begin
                  word_d       = sr_shift;
                  word_valid_d = 1'b1;
                  if (train_bad) cin_err_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.lock_status_o = (state_q == LOCKED);
   assign bus.cin_err_o     = cin_err_q;
   assign bus.word_o        = word_q;
   assign bus.word_valid_o  = word_valid_q;

`ifdef TURFIO_CIN_ERRCNT_EN
   logic [15:0] err_cnt_q;
   logic        err_clear;
   logic        err_event;

   assign err_clear = bus.lock_rst_i || bus.lock_req_i;
   assign err_event = (state_q == LOCKED) && boundary && train_bad;

   always_ff @(posedge aclk_i or posedge rst_i) begin
      if (rst_i)                                    err_cnt_q <= '0;
      else if (err_clear)                           err_cnt_q <= '0;
      else if (err_event && err_cnt_q != 16'hFFFF)  err_cnt_q <= err_cnt_q + 16'd1;
   end

   assign bus.err_count_o = err_cnt_q;
`else
   assign bus.err_count_o = 16'h0000;
`endif

endmodule
